// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: datapath width, opcodes, instruction field layout
// and the issue-controller state encoding.
package alu_pkg;

   localparam int DW  = 16;
   localparam int IW  = 16;
   localparam int OPW = 4;

   localparam int F_OP_LSB = 12;
   localparam int F_RD_LSB = 9;
   localparam int F_RA_LSB = 6;
   localparam int F_RB_LSB = 3;
   localparam int F_BA_BIT = 2;

   typedef enum logic [OPW-1:0] {
      OP_ADD   = 4'd0,
      OP_ADDSC = 4'd1,
      OP_SUB   = 4'd2,
      OP_ADD2B = 4'd3,
      OP_MUL   = 4'd4,
      OP_AND   = 4'd5,
      OP_SHL   = 4'd6,
      OP_SCALE = 4'd7
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   // The ALU implements opcodes 0..OP_SCALE only.
   function automatic logic op_illegal(input logic [OPW-1:0] op);
      return op > OP_SCALE;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, response, ALU-drive and host-load signals of the issue controller.
interface alu_issue_ctrl_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   import alu_pkg::*;

   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [3:0]    alu_op;
   logic          alu_ba;
   logic [DW-1:0] alu_out;
   logic          alu_carry;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_carry;
   logic          rsp_err;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          busy;

   modport slave (
      input  instr_valid, instr, alu_out, alu_carry, rsp_ready,
             host_we, host_addr, host_wdata,
      output instr_ready, alu_a, alu_b, alu_op, alu_ba,
             rsp_valid, rsp_data, rsp_carry, rsp_err, busy
   );

   modport master (
      output instr_valid, instr, alu_out, alu_carry, rsp_ready,
             host_we, host_addr, host_wdata,
      input  instr_ready, alu_a, alu_b, alu_op, alu_ba,
             rsp_valid, rsp_data, rsp_carry, rsp_err, busy
   );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREG x DW register file: two async read ports, one sync write port,
// entry 0 hardwired to zero, asynchronous active-low clear.
module alu_regfile #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   output logic [DW-1:0] o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [DW-1:0] o_rdata_b
);

   logic [DW-1:0] r_mem [NREG];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accept instruction, read operands, drive the
// ALU, capture result/carry, write back, then hand out a response.
module alu_issue_ctrl #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_issue_ctrl_if.slave bus
);
   import alu_pkg::*;

   state_e          r_state;
   logic            r_instr_ready;
   logic            r_busy;
   logic [OPW-1:0]  r_op;
   logic [AW-1:0]   r_rd;
   logic [AW-1:0]   r_ra;
   logic [AW-1:0]   r_rb;
   logic            r_ba;
   logic [DW-1:0]   r_alu_a;
   logic [DW-1:0]   r_alu_b;
   logic [OPW-1:0]  r_alu_op;
   logic            r_alu_ba;
   logic            r_rsp_valid;
   logic [DW-1:0]   r_rsp_data;
   logic            r_rsp_carry;
   logic            r_rsp_err;

   logic            w_accept;
   logic            w_we;
   logic [AW-1:0]   w_waddr;
   logic [DW-1:0]   w_wdata;
   logic [DW-1:0]   w_rdata_a;
   logic [DW-1:0]   w_rdata_b;
   logic            w_unused_rsvd;

   assign w_accept      = r_instr_ready && bus.instr_valid;
   assign w_unused_rsvd = ^bus.instr[1:0];

   // Host port owns the write port in IDLE, writeback owns it in WB.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (r_state == S_IDLE) begin
         w_we    = bus.host_we;
         w_waddr = bus.host_addr;
         w_wdata = bus.host_wdata;
      end else if (r_state == S_WB) begin
         w_we    = 1'b1;
         w_waddr = r_rd;
         w_wdata = r_rsp_data;
      end
   end

   alu_regfile #(
      .DW   (DW),
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_ra),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (r_rb),
      .o_rdata_b (w_rdata_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_instr_ready <= 1'b1;
         r_busy        <= 1'b0;
         r_op          <= '0;
         r_rd          <= '0;
         r_ra          <= '0;
         r_rb          <= '0;
         r_ba          <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_alu_ba      <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_carry   <= 1'b0;
         r_rsp_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op          <= bus.instr[F_OP_LSB +: OPW];
                  r_rd          <= bus.instr[F_RD_LSB +: AW];
                  r_ra          <= bus.instr[F_RA_LSB +: AW];
                  r_rb          <= bus.instr[F_RB_LSB +: AW];
                  r_ba          <= bus.instr[F_BA_BIT];
                  r_instr_ready <= 1'b0;
                  r_busy        <= 1'b1;
                  // Illegal opcodes skip the ALU and writeback entirely.
                  if (op_illegal(bus.instr[F_OP_LSB +: OPW])) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_carry <= 1'b0;
                  end else begin
                     r_state     <= S_ISSUE;
                     r_rsp_err   <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               r_alu_a  <= w_rdata_a;
               r_alu_b  <= w_rdata_b;
               r_alu_op <= r_op;
               r_alu_ba <= r_ba;
               r_state  <= S_EXEC;
            end
            S_EXEC: begin
               r_rsp_data  <= bus.alu_out;
               r_rsp_carry <= bus.alu_carry;
               r_state     <= S_WB;
            end
            S_WB: begin
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid   <= 1'b0;
                  r_instr_ready <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid   <= 1'b0;
               r_instr_ready <= 1'b1;
               r_busy        <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.instr_ready = r_instr_ready;
   assign bus.busy        = r_busy;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_op      = r_alu_op;
   assign bus.alu_ba      = r_alu_ba;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.rsp_carry   = r_rsp_carry;
   assign bus.rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 16-bit ALU as responder.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   alu_issue_ctrl_if #(.DW(16), .AW(3)) bus ();

   alu_issue_ctrl #(.DW(16), .NREG(8), .AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder ALU: carry is bit 16 of the widened result.
   logic [16:0] alu_t;
   always_comb begin
      alu_t = '0;
      case (bus.alu_op)
         OP_ADD:   alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         OP_ADDSC: alu_t = {1'b0, bus.alu_a} + ({1'b0, bus.alu_b} << bus.alu_ba) + {16'd0, bus.alu_ba};
         OP_SUB:   alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         OP_ADD2B: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 17'd2;
         OP_MUL:   alu_t = {1'b0, bus.alu_a * bus.alu_b};
         OP_AND:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
         OP_SHL:   alu_t = {1'b0, bus.alu_a} << bus.alu_b[3:0];
         OP_SCALE: alu_t = {1'b0, bus.alu_a} << bus.alu_ba;
         default:  alu_t = '0;
      endcase
   end
   assign bus.alu_out   = alu_t[15:0];
   assign bus.alu_carry = alu_t[16];

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic ba);
      return {op, rd, ra, rb, ba, 2'b00};
   endfunction

   task automatic host_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      @(negedge clk);
      bus.host_we    = 1'b0;
   endtask

   // Offers one instruction and waits (bounded) for rsp_valid; lat counts
   // edges from the accept edge (inclusive) to the one raising rsp_valid.
   task automatic run_instr(input logic [15:0] ins, input logic rdy,
                            output logic [15:0] d, output logic c,
                            output logic e, output int lat);
      @(negedge clk);
      bus.rsp_ready   = rdy;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         bus.instr_valid = 1'b0;
         lat++;
      end while (bus.rsp_valid !== 1'b1 && lat < 20);
      n_total++;
      if (bus.rsp_valid !== 1'b1)
         $display("FAIL rsp_timeout instr=%h rsp_valid=%b required 1", ins, bus.rsp_valid);
      else
         n_pass++;
      d = bus.rsp_data;
      c = bus.rsp_carry;
      e = bus.rsp_err;
      if (rdy) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
      logic c, e;
      int   lat;
      run_instr(enc(OP_ADD, 3'd0, a, 3'd0, 1'b0), 1'b1, v, c, e, lat);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_instr_ready", 16'(bus.instr_ready), 16'h1);
      chk("reset_busy", 16'(bus.busy), 16'h0);
      chk("reset_rsp_valid", 16'(bus.rsp_valid), 16'h0);
      chk("reset_alu_a", bus.alu_a, 16'h0);
      chk("reset_rsp_data", bus.rsp_data, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      logic [15:0] d, v;
      logic c, e;
      int lat;
      host_write(3'd1, 16'h0005);
      host_write(3'd2, 16'h0003);
      run_instr(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0), 1'b1, d, c, e, lat);
      chk("add_latency", 16'(lat), 16'd4);
      chk("add_data", d, 16'h0008);
      chk("add_err", 16'(e), 16'h0);
      read_reg(3'd3, v);
      chk("add_r3", v, 16'h0008);
   endtask

   task automatic test_dependency;
      logic [15:0] d;
      logic c, e;
      int lat;
      run_instr(enc(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0), 1'b1, d, c, e, lat);
      chk("dep_sub", d, 16'h0002);
      run_instr(enc(OP_ADD, 3'd5, 3'd4, 3'd4, 1'b0), 1'b1, d, c, e, lat);
      chk("dep_add", d, 16'h0004);
   endtask

   task automatic test_carry;
      logic [15:0] d;
      logic c, e;
      int lat;
      host_write(3'd1, 16'hFFFF);
      host_write(3'd2, 16'h0001);
      run_instr(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0), 1'b1, d, c, e, lat);
      chk("carry_data", d, 16'h0000);
      chk("carry_flag", 16'(c), 16'h1);
   endtask

   task automatic test_scale_shift;
      logic [15:0] d, v;
      logic c, e;
      int lat;
      host_write(3'd1, 16'h0010);
      host_write(3'd2, 16'h0004);
      run_instr(enc(OP_ADDSC, 3'd6, 3'd1, 3'd2, 1'b1), 1'b1, d, c, e, lat);
      chk("addsc_data", d, 16'h0019);
      run_instr(enc(OP_SHL, 3'd7, 3'd2, 3'd2, 1'b0), 1'b1, d, c, e, lat);
      chk("shl_data", d, 16'h0040);
      read_reg(3'd6, v);
      chk("addsc_r6", v, 16'h0019);
   endtask

   task automatic test_illegal;
      logic [15:0] d, v;
      logic c, e;
      int lat;
      run_instr(enc(4'h9, 3'd7, 3'd1, 3'd2, 1'b1), 1'b1, d, c, e, lat);
      chk("illegal_latency", 16'(lat), 16'd1);
      chk("illegal_err", 16'(e), 16'h1);
      chk("illegal_data", d, 16'h0000);
      chk("illegal_carry", 16'(c), 16'h0);
      chk("illegal_alu_a_held", bus.alu_a, 16'h0019);
      read_reg(3'd7, v);
      chk("illegal_r7_unchanged", v, 16'h0040);
   endtask

   task automatic test_backpressure;
      logic [15:0] d, v;
      logic c, e;
      int lat;
      int bad;
      run_instr(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0), 1'b0, d, c, e, lat);
      chk("bp_data", d, 16'h0014);
      bad = 0;
      @(negedge clk);
      bus.host_we    = 1'b1;
      bus.host_addr  = 3'd1;
      bus.host_wdata = 16'hAAAA;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0014 ||
             bus.instr_ready !== 1'b0 || bus.busy !== 1'b1)
            bad++;
      end
      chk("bp_hold_stable_errors", 16'(bad), 16'h0);
      @(negedge clk);
      bus.host_we   = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 16'(bus.rsp_valid), 16'h0);
      chk("bp_release_ready", 16'(bus.instr_ready), 16'h1);
      read_reg(3'd1, v);
      chk("bp_host_ignored_r1", v, 16'h0010);
      read_reg(3'd3, v);
      chk("bp_r3", v, 16'h0014);
   endtask

   task automatic test_host_at_accept;
      logic [15:0] v;
      int n;
      @(negedge clk);
      bus.host_we     = 1'b1;
      bus.host_addr   = 3'd2;
      bus.host_wdata  = 16'h0007;
      bus.instr       = enc(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0);
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.host_we     = 1'b0;
      bus.instr_valid = 1'b0;
      n = 1;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept_write_data", bus.rsp_data, 16'h0017);
      @(posedge clk);
      #1;
      read_reg(3'd2, v);
      chk("accept_write_r2", v, 16'h0007);
   endtask

   task automatic test_r0;
      logic [15:0] d, v;
      logic c, e;
      int lat;
      host_write(3'd0, 16'h1234);
      run_instr(enc(OP_ADD, 3'd0, 3'd1, 3'd1, 1'b0), 1'b1, d, c, e, lat);
      chk("r0_discard_result", d, 16'h0020);
      read_reg(3'd0, v);
      chk("r0_reads_zero", v, 16'h0000);
   endtask

   task automatic test_reset_mid;
      logic [15:0] v;
      @(negedge clk);
      bus.instr       = enc(OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0);
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_alu_a_before", bus.alu_a, 16'h0010);
      rst_n = 1'b0;
      #1;
      chk("mid_alu_a", bus.alu_a, 16'h0000);
      chk("mid_alu_b", bus.alu_b, 16'h0000);
      chk("mid_alu_op", 16'(bus.alu_op), 16'h0);
      chk("mid_rsp_data", bus.rsp_data, 16'h0000);
      chk("mid_busy", 16'(bus.busy), 16'h0);
      chk("mid_instr_ready", 16'(bus.instr_ready), 16'h1);
      @(negedge clk);
      rst_n = 1'b1;
      read_reg(3'd3, v);
      chk("mid_r3_reset_value", v, 16'h0000);
      read_reg(3'd1, v);
      chk("mid_r1_cleared", v, 16'h0000);
   endtask

   initial begin
      n_pass          = 0;
      n_total         = 0;
      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.rsp_ready   = 1'b1;
      bus.host_we     = 1'b0;
      bus.host_addr   = '0;
      bus.host_wdata  = '0;
      test_reset();
      test_add();
      test_dependency();
      test_carry();
      test_scale_shift();
      test_illegal();
      test_backpressure();
      test_host_at_accept();
      test_r0();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller on the operand/opcode side of the 16-bit ALU.
- Accepts packed instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives A/B/OP/BA into the ALU and captures its result and carry, then writes back.
- Returns a response over a second valid/ready handshake.

Parameters:
- DW, 16, datapath width; must match the ALU.
- NREG, 8, number of register-file entries; r0 reads as zero.
- AW, 3, register address width, log2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  16  fields: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2] ba, [1:0] reserved (ignored).
- alu_a  out  DW  to ALU A.
- alu_b  out  DW  to ALU B.
- alu_op  out  4  to ALU OP.
- alu_ba  out  1  to ALU BA.
- alu_out  in  DW  ALU result, combinational from alu_a/alu_b/alu_op/alu_ba.
- alu_carry  in  1  ALU carry flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DW  captured result.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  illegal opcode.
- host_we  in  1  register-file load strobe.
- host_addr  in  AW  load address.
- host_wdata  in  DW  load data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All register-file entries cleared to 0.
  - alu_a, alu_b, alu_op, alu_ba cleared to 0.
  - rsp_valid, rsp_data, rsp_carry, rsp_err cleared to 0.
  - instr_ready=1 after reset; busy=0.
  - Reset mid-operation abandons the instruction; no writeback occurs.
- States: IDLE -> ISSUE -> EXEC -> WB -> RESP -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready (edge T0), latch instr.
  - If op[3]==1 (opcodes 8..15 are unsupported by the ALU), go directly to RESP with rsp_err=1, rsp_data=0, rsp_carry=0; no ALU issue, no writeback.
  - Otherwise go to ISSUE.
- ISSUE (T1 edge):
  - Register alu_a=R[ra], alu_b=R[rb], alu_op=op, alu_ba=ba.
  - R[0] always reads 0.
- EXEC (T2 edge):
  - ALU is combinational; sample alu_out and alu_carry into rsp_data and rsp_carry.
- WB (T3 edge): write rsp_data to R[rd] unless rd==0, in which case the write is discarded.
- RESP:
  - rsp_valid=1; rsp_data, rsp_carry and rsp_err stay stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE and drop rsp_valid.
- Latency:
  - rsp_valid rises 4 cycles after the accept edge for legal ops; 1 cycle for illegal ops.
  - Throughput is one instruction per 5 cycles minimum.
- ALU drive outputs hold their last values outside ISSUE and are not cleared between instructions.
- Host load:
  - host_we is honoured only when busy=0.
  - A host write coinciding with an instruction accept is performed at that same edge, so ISSUE reads the new value.
  - host_we while busy=1 is ignored.
  - host writes to address 0 are discarded.
- Dependent instructions: writeback completes before RESP, so the next instruction always sees the prior result.
- rsp_ready asserted outside RESP has no effect.
- Width: all data is DW bits; no extension or saturation; the ALU result is taken as delivered.

Decomposition:
- Shared package alu_pkg holds:
  - DW;
  - opcode constants OP_ADD=0, OP_ADDSC=1, OP_SUB=2, OP_ADD2B=3, OP_MUL=4, OP_AND=5, OP_SHL=6, OP_SCALE=7;
  - instruction field bit positions;
  - state encoding.
- One sub-module: alu_regfile (NREG x DW, two async read ports, one sync write port, r0 hardwired zero, async active-low clear).

Test Plan (ALU instantiated as the responder):
- Host-load R1=0x0005, R2=0x0003; issue ADD rd=3,ra=1,rb=2 -> rsp_valid 4 cycles after accept, rsp_data=0x0008, rsp_err=0, R3=0x0008.
- R1=0x0005, R2=0x0003; SUB rd=4 then ADD rd=5,ra=4,rb=4 -> first rsp_data=0x0002, second rsp_data=0x0004 (dependency honoured).
- R1=0x0010, R2=0x0004; ADDSC ba=1 rd=6 -> rsp_data=0x0019; SHL ra=2,rb=2 rd=7 -> 0x0040.
- Opcode 0x9 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, no register changes.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, instr_ready=0, host_we ignored; release -> IDLE next cycle.
- Write rd=0 yields R0 still reads 0; assert rst_n=0 during EXEC -> all outputs 0, destination register unchanged from its reset value.
